// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - walks the register file then data memory, streaming (src, addr, data) records
// Optional checksum trailer record: define DUMP_CHECKSUM_EN.
module state_dump_unit #(
  parameter int DATA_W        = 8,
  parameter int REG_AW        = 3,
  parameter int MEM_AW        = 16,
  parameter int SKIP_ZERO_MEM = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_src,
  output logic [MEM_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [MEM_AW:0]   mem_rec_cnt
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REG     = 3'd1;
  localparam logic [2:0] MEM_RD  = 3'd2;
  localparam logic [2:0] MEM_CHK = 3'd3;
  localparam logic [2:0] EMIT    = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  localparam logic [REG_AW-1:0] REG_LAST = '1;
  localparam logic [MEM_AW-1:0] MEM_LAST = '1;
  localparam logic [MEM_AW:0]   CNT_MAX  = '1;

  logic [2:0]        state;
  logic [REG_AW-1:0] reg_idx;
  logic [MEM_AW-1:0] mem_addr;
  logic              xfer;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign xfer        = out_valid && out_ready;
  assign busy        = (state != IDLE) && (state != FIN);
  assign done        = (state == FIN);
  assign reg_rd_addr = reg_idx;
  assign mem_rd_en   = (state == MEM_RD);
  assign mem_rd_addr = mem_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      reg_idx     <= '0;
      mem_addr    <= '0;
      out_valid   <= 1'b0;
      out_src     <= 2'd0;
      out_addr    <= '0;
      out_data    <= '0;
      mem_rec_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum         <= '0;
`endif
    end else if (abort) begin
      // Also covers start+abort in IDLE: abort wins and the FSM stays idle.
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= REG;
            reg_idx     <= '0;
            mem_rec_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum         <= '0;
`endif
          end
        end
        REG: begin
          out_src   <= 2'd0;
          out_addr  <= MEM_AW'(reg_idx);
          out_data  <= reg_rd_data;
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        MEM_RD: state <= MEM_CHK;
        MEM_CHK: begin
          if ((SKIP_ZERO_MEM != 0) && (mem_rd_data == '0)) begin
            if (mem_addr == MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
              out_src   <= 2'd2;
              out_addr  <= '0;
              out_data  <= sum;
              out_valid <= 1'b1;
              state     <= EMIT;
`else
              state     <= FIN;
`endif
            end else begin
              mem_addr <= mem_addr + 1'b1;
              state    <= MEM_RD;
            end
          end else begin
            out_src   <= 2'd1;
            out_addr  <= mem_addr;
            out_data  <= mem_rd_data;
            out_valid <= 1'b1;
            if (mem_rec_cnt != CNT_MAX) mem_rec_cnt <= mem_rec_cnt + 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            out_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            if (out_src != 2'd2) sum <= sum + out_data;
`endif
            case (out_src)
              2'd0: begin
                if (reg_idx == REG_LAST) begin
                  mem_addr <= '0;
                  state    <= MEM_RD;
                end else begin
                  reg_idx <= reg_idx + 1'b1;
                  state   <= REG;
                end
              end
              2'd1: begin
                if (mem_addr == MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
                  // Trailer must include the record that is transferring right now.
                  out_src   <= 2'd2;
                  out_addr  <= '0;
                  out_data  <= sum + out_data;
                  out_valid <= 1'b1;
                  state     <= EMIT;
`else
                  state     <= FIN;
`endif
                end else begin
                  mem_addr <= mem_addr + 1'b1;
                  state    <= MEM_RD;
                end
              end
              default: state <= FIN;
            endcase
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// tb/tb_state_dump_unit.sv - directed and randomized checks of state_dump_unit against a record-list model
module tb_state_dump_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_start, a_abort, a_busy, a_done, a_mem_rd_en, a_out_valid, a_out_ready;
  logic [2:0] a_reg_rd_addr;
  logic [7:0] a_mem_rd_addr, a_out_addr, a_reg_rd_data, a_mem_rd_data, a_out_data;
  logic [1:0] a_out_src;
  logic [8:0] a_mem_rec_cnt;

  logic       b_start, b_abort, b_busy, b_done, b_mem_rd_en, b_out_valid, b_out_ready;
  logic [2:0] b_reg_rd_addr;
  logic [3:0] b_mem_rd_addr, b_out_addr;
  logic [7:0] b_reg_rd_data, b_mem_rd_data, b_out_data;
  logic [1:0] b_out_src;
  logic [4:0] b_mem_rec_cnt;

  state_dump_unit #(.DATA_W(8), .REG_AW(3), .MEM_AW(8), .SKIP_ZERO_MEM(1)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .busy(a_busy), .done(a_done),
    .reg_rd_addr(a_reg_rd_addr), .reg_rd_data(a_reg_rd_data),
    .mem_rd_en(a_mem_rd_en), .mem_rd_addr(a_mem_rd_addr), .mem_rd_data(a_mem_rd_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_src(a_out_src),
    .out_addr(a_out_addr), .out_data(a_out_data), .mem_rec_cnt(a_mem_rec_cnt)
  );

  state_dump_unit #(.DATA_W(8), .REG_AW(3), .MEM_AW(4), .SKIP_ZERO_MEM(0)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
    .reg_rd_addr(b_reg_rd_addr), .reg_rd_data(b_reg_rd_data),
    .mem_rd_en(b_mem_rd_en), .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_src(b_out_src),
    .out_addr(b_out_addr), .out_data(b_out_data), .mem_rec_cnt(b_mem_rec_cnt)
  );

  logic [7:0] regs [8];
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];

  assign a_reg_rd_data = regs[a_reg_rd_addr];
  assign b_reg_rd_data = regs[b_reg_rd_addr];
  always @(posedge clk) if (a_mem_rd_en) a_mem_rd_data <= mem_a[a_mem_rd_addr];
  always @(posedge clk) if (b_mem_rd_en) b_mem_rd_data <= mem_b[b_mem_rd_addr];

  // Records are {src[1:0], addr[15:0], data[7:0]}.
  logic [25:0] got_a[$];
  logic [25:0] got_b[$];
  logic [25:0] exp_q[$];
  int done_a, done_b, exp_cnt;
  int checks, errors;
  int n, d0;

  always @(negedge clk) begin
    if (!reset) begin
      if (a_out_valid && a_out_ready) got_a.push_back({a_out_src, 8'd0, a_out_addr, a_out_data});
      if (b_out_valid && b_out_ready) got_b.push_back({b_out_src, 12'd0, b_out_addr, b_out_data});
      if (a_done) done_a++;
      if (b_done) done_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stream: every register, then memory words (non-zero only when skipping), then optional checksum.
  function automatic void build_exp(input bit use_b);
    logic [7:0] sum;
    logic [7:0] w;
    int words;
    sum = 8'd0;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'd0, 16'(i), regs[i]});
      sum = sum + regs[i];
    end
    words = use_b ? 16 : 256;
    for (int a = 0; a < words; a++) begin
      if (use_b) w = mem_b[a];
      else       w = mem_a[a];
      if (use_b || w != 8'd0) begin
        exp_q.push_back({2'd1, 16'(a), w});
        sum = sum + w;
        exp_cnt++;
      end
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back({2'd2, 16'd0, sum});
`endif
  endfunction

  task automatic cmp_stream(input string tag, input bit use_b);
    logic [25:0] got[$];
    int cnt;
    build_exp(use_b);
    if (use_b) begin
      got = got_b;
      cnt = int'(b_mem_rec_cnt);
    end else begin
      got = got_a;
      cnt = int'(a_mem_rec_cnt);
    end
    check($sformatf("%s_len", tag), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_rec%0d", tag, i), got[i], exp_q[i]);
    check($sformatf("%s_cnt", tag), cnt, exp_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic run_a(input int ready_pct, input bit poke_start);
    int k;
    bit poked;
    k = 0;
    poked = 1'b0;
    while (!a_done && k < 5000) begin
      a_out_ready = ($urandom_range(99) < ready_pct);
      a_start = poke_start && !poked && a_mem_rd_en && (k > 30);
      if (a_start) poked = 1'b1;
      tick();
      k++;
    end
    a_start = 1'b0;
    a_out_ready = 1'b1;
    check("a_done_seen", a_done, 1'b1);
    if (poke_start) check("a_start_poked", poked, 1'b1);
  endtask

  task automatic wait_a_reg(input logic [7:0] idx);
    int k;
    k = 0;
    while (!(a_out_valid && a_out_src == 2'd0 && a_out_addr == idx) && k < 200) begin
      tick();
      k++;
    end
    check("a_reach_reg", k < 200, 1'b1);
  endtask

  task automatic wait_a_cnt1();
    int k;
    k = 0;
    while (a_mem_rec_cnt != 9'd1 && k < 400) begin
      tick();
      k++;
    end
    check("a_reach_cnt1", k < 400, 1'b1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) regs[i] = 8'(3 * i);
    for (int i = 0; i < 256; i++) mem_a[i] = 8'd0;
    mem_a[5] = 8'd9;
    mem_a[254] = 8'd200;
  endtask

  initial begin
    reset = 1'b1;
    a_start = 0; a_abort = 0; a_out_ready = 1;
    b_start = 0; b_abort = 0; b_out_ready = 1;
    load_basic();
    for (int i = 0; i < 16; i++) mem_b[i] = 8'd0;
    tick();
    tick();
    check("rst_a_ctl", {a_busy, a_done, a_out_valid, a_mem_rd_en, a_out_src}, 0);
    check("rst_a_rec", {a_out_addr, a_out_data}, 0);
    check("rst_a_addr", {a_reg_rd_addr, a_mem_rd_addr}, 0);
    check("rst_a_cnt", a_mem_rec_cnt, 0);
    check("rst_b_all", {b_busy, b_done, b_out_valid, b_mem_rd_en, b_out_src, b_mem_rec_cnt}, 0);
    reset = 1'b0;
    tick();

    // Basic dump: latency, exact stream, completion timing.
    got_a.delete(); d0 = done_a;
    start_a();
    check("s1_busy_n", a_busy, 1'b1);
    check("s1_valid_n", a_out_valid, 1'b0);
    tick();
    check("s1_valid_n1", a_out_valid, 1'b1);
    check("s1_first", {a_out_src, a_out_addr, a_out_data}, {2'd0, 8'd0, 8'd0});
    n = 0;
    while (!a_done && n < 2000) begin tick(); n++; end
    check("s1_done_time", (n >= 529) && (n <= 531), 1'b1);
    tick();
    check("s1_idle", {a_busy, a_done}, 0);
    cmp_stream("s1", 1'b0);
    check("s1_done_once", done_a - d0, 1);
`ifdef DUMP_CHECKSUM_EN
    if (got_a.size() > 0) check("s6_trailer", got_a[got_a.size()-1], {2'd2, 16'd0, 8'd37});
`endif

    // Backpressure on reg 3.
    got_a.delete(); d0 = done_a;
    start_a();
    wait_a_reg(8'd3);
    a_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("s2_hold%0d", k), {a_out_valid, a_out_src, a_out_addr, a_out_data}, {1'b1, 2'd0, 8'd3, 8'd9});
    end
    a_out_ready = 1'b1;
    run_a(100, 1'b0);
    tick();
    cmp_stream("s2", 1'b0);
    check("s2_done_once", done_a - d0, 1);

    // Start pulsed during the memory scan is ignored.
    got_a.delete(); d0 = done_a;
    start_a();
    run_a(100, 1'b1);
    tick();
    cmp_stream("s3", 1'b0);
    check("s3_done_once", done_a - d0, 1);

    // Abort while stalled on reg 5, then restart.
    got_a.delete(); d0 = done_a;
    start_a();
    wait_a_reg(8'd5);
    a_out_ready = 1'b0;
    tick();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("s4_abort", {a_out_valid, a_busy, a_mem_rd_en}, 0);
    tick();
    tick();
    check("s4_no_done", done_a - d0, 0);
    got_a.delete(); a_out_ready = 1'b1;
    start_a();
    tick();
    check("s4_restart", {a_out_valid, a_out_src, a_out_addr, a_out_data}, {1'b1, 2'd0, 8'd0, 8'd0});
    run_a(100, 1'b0);
    tick();
    cmp_stream("s4", 1'b0);

    // Abort mid-memory keeps the record count; abort beats start.
    start_a();
    wait_a_cnt1();
    a_abort = 1'b1; a_start = 1'b1;
    tick();
    a_abort = 1'b0; a_start = 1'b0;
    check("s4_abort_mem", {a_busy, a_out_valid, a_mem_rd_en}, 0);
    check("s4_cnt_kept", a_mem_rec_cnt, 1);
    a_abort = 1'b1; a_start = 1'b1;
    tick();
    a_abort = 1'b0; a_start = 1'b0;
    check("s4_abort_wins", a_busy, 1'b0);

    // Reset mid-memory-scan.
    start_a();
    wait_a_cnt1();
    reset = 1'b1;
    tick();
    check("s4_rst_ctl", {a_busy, a_done, a_out_valid, a_mem_rd_en, a_out_src}, 0);
    check("s4_rst_cnt", a_mem_rec_cnt, 0);
    reset = 1'b0;
    tick();

    // Randomized contents and backpressure.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom_range(255));
      for (int i = 0; i < 256; i++) mem_a[i] = ($urandom_range(15) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      if (it == 0) begin
        mem_a[0] = 8'($urandom_range(255, 1));
        mem_a[255] = 8'($urandom_range(255, 1));
      end
      got_a.delete(); d0 = done_a;
      start_a();
      run_a(60, it == 1);
      tick();
      cmp_stream($sformatf("rnd%0d", it), 1'b0);
      check($sformatf("rnd%0d_done_once", it), done_a - d0, 1);
    end

    // No skipping, 16-word memory: all zero, then random with backpressure.
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 16; i++) mem_b[i] = (it == 0) ? 8'd0 : 8'($urandom_range(255));
      got_b.delete(); d0 = done_b;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      n = 0;
      while (!b_done && n < 500) begin
        b_out_ready = (it == 0) || ($urandom_range(99) < 70);
        tick();
        n++;
      end
      b_out_ready = 1'b1;
      check($sformatf("s5_%0d_done_seen", it), b_done, 1'b1);
      tick();
      cmp_stream($sformatf("s5_%0d", it), 1'b1);
      check($sformatf("s5_%0d_cnt16", it), b_mem_rec_cnt, 16);
      check($sformatf("s5_%0d_done_once", it), done_b - d0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Synthesizable architectural-state dump engine for the 8-bit RISC/RNS core.
- On command it walks the register file and then data memory, streaming (source, address, data) records over a valid/ready interface to a debug UART/trace port.
- It replaces end-of-simulation print loops so the same dump works on silicon/FPGA.
- Parametrised in data width, register depth and memory depth; it skips zero memory words and has an abort path.

Parameters:
- DATA_W, 8: register and memory word width.
- REG_AW, 3: register-file address width; 2^REG_AW registers are dumped.
- MEM_AW, 16: data-memory address width; 2^MEM_AW words are scanned.
- SKIP_ZERO_MEM, 1: 1 = emit only non-zero memory words; 0 = emit every word.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: begin a dump; sampled only in IDLE.
- abort, in, 1: terminate the dump.
- busy, out, 1: high from the cycle after start until return to IDLE.
- done, out, 1: one-cycle pulse on normal completion.
- reg_rd_addr, out, REG_AW: register-file read address. The read is combinational, so data returns in the same cycle.
- reg_rd_data, in, DATA_W: register read data.
- mem_rd_en, out, 1: memory read strobe.
- mem_rd_addr, out, MEM_AW: memory read address.
- mem_rd_data, in, DATA_W: memory read data, valid the cycle after mem_rd_en.
- out_valid, out, 1: record valid.
- out_ready, in, 1: sink ready.
- out_src, out, 2: record source. 0 = register, 1 = memory, 2 = checksum (optional feature only).
- out_addr, out, MEM_AW: record address. Register indices are zero-extended.
- out_data, out, DATA_W: record data.
- mem_rec_cnt, out, MEM_AW+1: number of memory records emitted in the current or last dump.

Behaviour:
- Reset values (while reset is high, synchronous): state IDLE; all outputs 0, including mem_rec_cnt, out_valid, mem_rd_en and done.
- FSM states: IDLE, REG, MEM_RD, MEM_CHK, EMIT, FIN.
- IDLE: start=1 → REG with reg index 0; mem_rec_cnt cleared. start while not IDLE is ignored.
- REG:
  - Drive reg_rd_addr = idx and capture reg_rd_data into the output register.
  - Next state EMIT with out_src=0 and out_valid=1.
  - Every register is emitted, including zero-valued ones.
- EMIT:
  - Hold out_valid and out_src/out_addr/out_data stable until out_valid&out_ready; no payload change while stalled.
  - On transfer, out_valid drops only if the next state does not immediately re-assert it.
  - After a register transfer: next index → REG, or after the last index (2^REG_AW-1) → MEM_RD with address 0.
  - After a memory transfer: address == 2^MEM_AW-1 → FIN, else address+1 → MEM_RD.
- MEM_RD: mem_rd_en=1 for exactly one cycle with mem_rd_addr = addr → MEM_CHK.
- MEM_CHK:
  - If SKIP_ZERO_MEM and mem_rd_data==0: no record; go to MEM_RD with addr+1, or to FIN if addr is the last address.
  - Otherwise load the record with out_src=1, increment mem_rec_cnt (saturating at 2^(MEM_AW+1)-1), and go to EMIT.
- Throughput:
  - Register records: one per 2 cycles with out_ready held high.
  - Each skipped memory word costs 2 cycles; each emitted memory word costs 3 cycles minimum.
- Address counter wraps are never used; termination is by explicit last-address compare, so MEM_AW=16 scans 0..65535 inclusive.
- FIN: done=1 for one cycle, busy=0 in the same cycle → IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle the FSM is in IDLE with out_valid=0 and mem_rd_en=0, even mid-handshake. The pending record is dropped.
  - done is not pulsed; mem_rec_cnt is retained.
- Simultaneous events:
  - abort with start in IDLE: abort wins, stay IDLE.
  - reset overrides abort and start.
  - Reset mid-dump is equivalent to abort, plus mem_rec_cnt is cleared.
- Latency: start asserted at edge N → busy=1 and out_valid=1 for register 0 after edge N+1.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
  - When defined: a DATA_W-bit running sum, modulo 2^DATA_W, accumulates every emitted record's out_data. FIN is preceded by one extra EMIT record with out_src=2, out_addr=0 and out_data=sum, obeying the same handshake; done pulses after its transfer. The sum clears on start.
  - When undefined: no accumulator; out_src never equals 2.

Test Plan:
- Scenario 1, basic dump (MEM_AW=16, SKIP_ZERO_MEM=1, out_ready=1):
  - Stimulus: regs[i]=3*i; mem[5]=9, mem[65534]=200, rest 0; pulse start.
  - Required: 8 register records (0,0)…(7,21); then memory records (5,9) and (65534,200); mem_rec_cnt=2; done pulses once.
  - Required timing: done exactly 16 + 2*65536 + 2 cycles after first out_valid ±1 (per throughput rules).
- Scenario 2, backpressure: out_ready=0 for 4 cycles while record for reg 3 is valid → out_addr=3 and out_data=9 held constant all 4 cycles; no record lost or duplicated.
- Scenario 3, start during busy: start pulsed while in memory scan → ignored; record stream identical to scenario 1.
- Scenario 4, abort and reset mid-dump:
  - abort at the stall on reg 5 → out_valid=0 and busy=0 the next cycle; no done; a new start restarts at reg 0.
  - reset mid-memory-scan → all outputs 0 and mem_rec_cnt=0 the next cycle.
- Scenario 5, no skipping (SKIP_ZERO_MEM=0, MEM_AW=4, mem all 0) → 8 register records + 16 memory records with data 0; mem_rec_cnt=16.
- Scenario 6, checksum (DUMP_CHECKSUM_EN defined, scenario-1 data) → final record out_src=2 with out_data=(84+9+200) mod 256 = 37; done after its transfer.
